// File: rtl/max_tree_stream.sv
// Pipelined FANIN-ary max-reduction tree over LANES signed scores, folded into a per-frame running max.
// Define MAXTREE_ARGMAX_EN to build the lane/beat index tracking behind beat_lane and frame_idx.
module max_tree_stream #(
  parameter int  DATA_WIDTH = 18,
  parameter int  LANES      = 64,
  parameter int  FANIN      = 8,
  parameter int  BEAT_WIDTH = 16,
  localparam int LANE_W     = $clog2(LANES),
  localparam int IDX_WIDTH  = LANE_W + BEAT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  input  logic                        in_last,
  input  logic                        clear,
  output logic                        beat_valid,
  output logic [DATA_WIDTH-1:0]       beat_max,
  output logic [LANE_W-1:0]           beat_lane,
  output logic                        frame_valid,
  output logic [DATA_WIDTH-1:0]       frame_max,
  output logic [IDX_WIDTH-1:0]        frame_idx
);

  localparam int STAGES = LANE_W / $clog2(FANIN);
  // All tree stages share one flat node array; stage 1 first, root last.
  localparam int NODES  = (LANES - 1) / (FANIN - 1);
  localparam int ROOT   = NODES - 1;

  function automatic logic signed [DATA_WIDTH-1:0] clamp0(input logic signed [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? '0 : v;
  endfunction

  function automatic int stage_off(input int s);
    int o;
    int n;
    o = 0;
    n = LANES;
    for (int j = 1; j < s; j++) begin
      n = n / FANIN;
      o = o + n;
    end
    return o;
  endfunction

  logic signed [DATA_WIDTH-1:0] tree_val_d [NODES];
  logic signed [DATA_WIDTH-1:0] tree_val_p [NODES];
  logic signed [DATA_WIDTH-1:0] best_v, cand_v;
  logic [STAGES-1:0]            vld_p, last_p;
`ifdef MAXTREE_ARGMAX_EN
  logic [LANE_W-1:0]            tree_lane_d [NODES];
  logic [LANE_W-1:0]            tree_lane_p [NODES];
  logic [LANE_W-1:0]            best_l, cand_l;
`endif

  // Node compares: inputs clamped at 0, strict > so the lower-indexed input keeps ties.
  always_comb begin
    best_v = '0;
    cand_v = '0;
    for (int i = 0; i < NODES; i++) tree_val_d[i] = '0;
`ifdef MAXTREE_ARGMAX_EN
    best_l = '0;
    cand_l = '0;
    for (int i = 0; i < NODES; i++) tree_lane_d[i] = '0;
`endif
    for (int s = 1; s <= STAGES; s++) begin
      for (int n = 0; n < LANES / FANIN; n++) begin
        if (n < LANES / (FANIN ** s)) begin
          for (int k = 0; k < FANIN; k++) begin
            if (s == 1) begin
              cand_v = clamp0(in_data[(n*FANIN+k)*DATA_WIDTH +: DATA_WIDTH]);
`ifdef MAXTREE_ARGMAX_EN
              cand_l = LANE_W'(n*FANIN+k);
`endif
            end else begin
              cand_v = tree_val_p[stage_off(s-1) + n*FANIN + k];
`ifdef MAXTREE_ARGMAX_EN
              cand_l = tree_lane_p[stage_off(s-1) + n*FANIN + k];
`endif
            end
            if (k == 0 || cand_v > best_v) begin
              best_v = cand_v;
`ifdef MAXTREE_ARGMAX_EN
              best_l = cand_l;
`endif
            end
          end
          tree_val_d[stage_off(s) + n] = best_v;
`ifdef MAXTREE_ARGMAX_EN
          tree_lane_d[stage_off(s) + n] = best_l;
`endif
        end
      end
    end
  end

  // Stage registers p0..p(STAGES-1); valid and last ride with their beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) tree_val_p[i] <= '0;
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      for (int i = 0; i < NODES; i++) tree_val_p[i] <= tree_val_d[i];
      vld_p[0]  <= in_valid & ~clear;
      last_p[0] <= in_last;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s]  <= vld_p[s-1] & ~clear;
        last_p[s] <= last_p[s-1];
      end
    end
  end

`ifdef MAXTREE_ARGMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) tree_lane_p[i] <= '0;
    end else begin
      for (int i = 0; i < NODES; i++) tree_lane_p[i] <= tree_lane_d[i];
    end
  end
`endif

  assign beat_valid = vld_p[STAGES-1];
  assign beat_max   = tree_val_p[ROOT];

  logic signed [DATA_WIDTH-1:0] acc_max, frame_max_r, merge_max;
  logic                         start, take, frame_valid_r;

  // A frame's first beat always loads; later beats replace only on a strictly larger max.
  assign take      = start || (tree_val_p[ROOT] > acc_max);
  assign merge_max = take ? tree_val_p[ROOT] : acc_max;

  // Accumulator stage: folds output beats, publishes the frame result on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_max       <= '0;
      start         <= 1'b1;
      frame_valid_r <= 1'b0;
      frame_max_r   <= '0;
    end else if (clear) begin
      acc_max       <= '0;
      start         <= 1'b1;
      frame_valid_r <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      if (beat_valid) begin
        acc_max <= merge_max;
        start   <= last_p[STAGES-1];
        if (last_p[STAGES-1]) begin
          frame_valid_r <= 1'b1;
          frame_max_r   <= merge_max;
        end
      end
    end
  end

  assign frame_valid = frame_valid_r;
  assign frame_max   = frame_max_r;

`ifdef MAXTREE_ARGMAX_EN
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [IDX_WIDTH-1:0]  acc_idx, frame_idx_r, merge_idx;

  assign merge_idx = take ? {beat_cnt, tree_lane_p[ROOT]} : acc_idx;

  // Beat counter saturates so very long frames keep reporting the last countable beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      acc_idx     <= '0;
      frame_idx_r <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      acc_idx  <= '0;
    end else if (beat_valid) begin
      acc_idx <= merge_idx;
      if (last_p[STAGES-1]) begin
        frame_idx_r <= merge_idx;
        beat_cnt    <= '0;
      end else if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign beat_lane = tree_lane_p[ROOT];
  assign frame_idx = frame_idx_r;
`else
  assign beat_lane = '0;
  assign frame_idx = '0;
`endif

endmodule
